// File: rtl/calc_cmd_initiator.sv
// Initiator end of the calculator operand interface: issues tagged commands to a
// 1-cycle registered core and returns tagged results through a credit-guarded FIFO.
module calc_cmd_initiator #(
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_high,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      calc_a,
  output logic [31:0]      calc_b,
  output logic [2:0]       calc_opcode,
  input  logic [32:0]      calc_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [32:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int OW = AW + 2;
  localparam int EW = 33 + TAG_W + 1;

  logic             s1_v, s1_err, s2_v, s2_err;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  logic [EW-1:0]    mem [RSP_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_count;
  logic [EW-1:0]    head;

  logic             accept, push, pop, req_err;
  logic [OW-1:0]    occupancy;

  // Credits count every command that will eventually land in the FIFO, so a
  // push can never meet a full FIFO regardless of response backpressure.
  always_comb begin
    occupancy = OW'(fifo_count) + OW'(s1_v) + OW'(s2_v);
    req_ready = !reset_high && (occupancy < OW'(RSP_DEPTH));
  end

  always_comb begin
    accept = req_valid && req_ready;
    push   = s2_v;
    pop    = rsp_valid && rsp_ready;
  end

  always_comb begin
    req_err = 1'b1;
    case (req_op)
      3'd1, 3'd2, 3'd3: req_err = 1'b0;
      3'd4:             req_err = (req_b == '0);
      default:          req_err = 1'b1;
    endcase
  end

  // Drive stage: operands hold when idle, opcode returns to 0.
  always_ff @(posedge clk) begin
    if (reset_high) begin
      calc_a       <= '0;
      calc_b       <= '0;
      calc_opcode  <= '0;
      s1_v         <= 1'b0;
      s1_tag       <= '0;
      s1_err       <= 1'b0;
      issued_count <= '0;
    end else if (accept) begin
      calc_a       <= req_a;
      calc_b       <= req_b;
      calc_opcode  <= req_op;
      s1_v         <= 1'b1;
      s1_tag       <= req_tag;
      s1_err       <= req_err;
      issued_count <= issued_count + CNT_W'(1);
    end else begin
      calc_opcode  <= '0;
      s1_v         <= 1'b0;
    end
  end

  // Result-wait stage: advances every cycle, the pipeline never stalls.
  always_ff @(posedge clk) begin
    if (reset_high) begin
      s2_v   <= 1'b0;
      s2_tag <= '0;
      s2_err <= 1'b0;
    end else begin
      s2_v   <= s1_v;
      s2_tag <= s1_tag;
      s2_err <= s1_err;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {calc_result, s2_tag, s2_err};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_high) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head is masked while empty so stale storage never shows on rsp_*.
  always_comb begin
    head       = mem[rd_ptr];
    rsp_valid  = (fifo_count != '0);
    rsp_result = rsp_valid ? head[EW-1 -: 33] : '0;
    rsp_tag    = rsp_valid ? head[TAG_W:1] : '0;
    rsp_err    = rsp_valid ? head[0] : 1'b0;
    busy       = s1_v || s2_v || (fifo_count != '0);
  end

endmodule

// File: tb/tb_calc_cmd_initiator.sv
// Self-checking bench for calc_cmd_initiator: core model plus a queue-based
// reference that tracks outstanding commands, their results and visibility time.
`timescale 1ns/1ps
module tb_calc_cmd_initiator;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset_high;
  logic          req_valid, req_ready;
  logic [31:0]   req_a, req_b;
  logic [2:0]    req_op;
  logic [TW-1:0] req_tag;
  logic [31:0]   calc_a, calc_b;
  logic [2:0]    calc_opcode;
  logic [32:0]   calc_result;
  logic          rsp_valid, rsp_ready;
  logic [32:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err, busy;
  logic [CW-1:0] issued_count;

  always #5 clk = ~clk;

  calc_cmd_initiator #(.RSP_DEPTH(DEPTH), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset_high(reset_high),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .calc_a(calc_a), .calc_b(calc_b), .calc_opcode(calc_opcode),
    .calc_result(calc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .issued_count(issued_count)
  );

  function automatic logic [32:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'd1:    return 33'(a) + 33'(b);
      3'd2:    return 33'(a) - 33'(b);
      3'd3:    return p[32:0];
      3'd4:    return (b == 32'd0) ? 33'd0 : 33'(a / b);
      default: return 33'd0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op, input logic [31:0] b);
    return (op == 3'd0) || (op > 3'd4) || (op == 3'd4 && b == 32'd0);
  endfunction

  // Calculator core: one registered stage.
  always_ff @(posedge clk) calc_result <= ref_res(calc_a, calc_b, calc_opcode);

  typedef struct {
    logic [32:0]   res;
    logic [TW-1:0] tag;
    logic          err;
    int            rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;
  logic        acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check every output against the model, then
  // account for the handshakes that the following posedge performs.
  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [TW-1:0] tag,
                      input logic rr, output logic accepted);
    logic er, ev;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_op = op; req_tag = tag; rsp_ready = rr;
    #1;
    er = (exp_q.size() < DEPTH);
    ev = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("busy", 64'(busy), 64'(exp_q.size() > 0));
    chk("issued_count", 64'(issued_count), 64'(exp_cnt % 65536));
    chk("fifo_bound", 64'(dut.fifo_count <= 3'd4), 64'(1));
    if (ev) begin
      chk("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
      chk("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
      chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
      if (rr) void'(exp_q.pop_front());
    end
    accepted = v && er;
    if (accepted) begin
      exp_q.push_back('{res: ref_res(a, b, op), tag: tag, err: ref_err(op, b), rdy: cyc + 3});
      exp_cnt++;
    end
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic rr);
    logic got;
    int   n = 0;
    do begin
      tick(1'b1, a, b, op, tag, rr, got);
      n++;
    end while (!got && n < 50);
    chk("send_accept", 64'(got), 64'(1));
  endtask

  task automatic idle(input logic rr);
    logic got;
    tick(1'b0, 32'd0, 32'd0, 3'd0, '0, rr, got);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_high = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'(0));
    exp_q.delete();
    exp_cnt = 0;
    cyc++;
    @(negedge clk);
    reset_high = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_issued", 64'(issued_count), 64'(0));
    chk("rst_calc_opcode", 64'(calc_opcode), 64'(0));
    chk("rst_calc_a", 64'(calc_a), 64'(0));
    chk("rst_calc_b", 64'(calc_b), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    cyc++;
  endtask

  initial begin
    int          k;
    int          n;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic        rr;

    reset_high = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_op = '0; req_tag = '0; rsp_ready = 1'b0;
    do_reset();

    // Single add
    send(32'd5, 32'd7, 3'd1, 4'd3, 1'b1);
    drain();

    // Back-to-back burst
    send(32'd3, 32'd5, 3'd2, 4'd0, 1'b1);
    send(32'hFFFF_FFFF, 32'd2, 3'd3, 4'd1, 1'b1);
    send(32'd100, 32'd7, 3'd4, 4'd2, 1'b1);
    drain();

    // Backpressure: only DEPTH commands may be outstanding
    k = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 32'(100 + k), 32'(k), 3'd1, TW'(k + 4), 1'b0, acc);
      if (acc) k++;
    end
    idle(1'b0);
    idle(1'b0);
    while (k < 6) begin
      send(32'(100 + k), 32'(k), 3'd1, TW'(k + 4), 1'b1);
      k++;
    end
    drain();

    // Error flags
    send(32'd9, 32'd0, 3'd4, 4'd10, 1'b1);
    send(32'd11, 32'd12, 3'd6, 4'd11, 1'b1);
    send(32'd9, 32'd3, 3'd4, 4'd12, 1'b1);
    send(32'd1, 32'd1, 3'd0, 4'd13, 1'b1);
    drain();

    // Reset mid-operation, then a fresh command
    send(32'd1, 32'd2, 3'd1, 4'd1, 1'b1);
    send(32'd3, 32'd4, 3'd1, 4'd2, 1'b1);
    do_reset();
    send(32'd20, 32'd22, 3'd1, 4'd9, 1'b1);
    drain();

    // Near-full FIFO with toggling consumer and random commands
    send(32'd1, 32'd1, 3'd1, 4'd1, 1'b0);
    send(32'd2, 32'd2, 3'd1, 4'd2, 1'b0);
    send(32'd3, 32'd3, 3'd1, 4'd3, 1'b0);
    idle(1'b0);
    idle(1'b0);
    send(32'd4, 32'd4, 3'd3, 4'd4, 1'b0);
    rr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rop = 3'($urandom_range(0, 7));
      tick(1'b1, ra, rb, rop, TW'($urandom), rr, acc);
      rr = ~rr;
    end
    drain();

    // issued_count wrap through 2^CW accepts
    n = 0;
    while ((exp_cnt % 65536) != 0 && n < 70000) begin
      ra  = $urandom;
      rb  = $urandom_range(0, 50);
      rop = 3'($urandom_range(1, 4));
      tick(1'b1, ra, rb, rop, TW'($urandom), 1'b1, acc);
      n++;
    end
    drain();
    chk("issued_wrap", 64'(issued_count), 64'(exp_cnt % 65536));
    chk("wrap_reached", 64'(exp_cnt), 64'(65536));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
